// File: rtl/operand_pkg.sv
// Shared operand-select constants: default geometry and the source index map
// used by the control decoder and forwarding unit.
package operand_pkg;

    localparam int OP_WIDTH = 32;
    localparam int OP_NSRC  = 4;
    localparam int OP_CNTW  = 8;

    localparam int SRC_GRF   = 0;
    localparam int SRC_EXT   = 1;
    localparam int SRC_FWD_M = 2;
    localparam int SRC_FWD_W = 3;

    // Nonzero count wraps would hide long stalls, so the counter pins at max.
    function automatic logic [OP_CNTW-1:0] sat_inc8(input logic [OP_CNTW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/operand_mux_comb.sv
// Purely combinational NSRC:1 word mux; reports whether the select names a real source.
module operand_mux_comb #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC*WIDTH-1:0] src_data_i,
    input  logic [SELW-1:0]       sel_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  in_range_o
);

    localparam logic [SELW:0] NSRC_L = (SELW+1)'(NSRC);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_i == SELW'(i)) begin
                data_o = src_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_range_o = ({1'b0, sel_i} < NSRC_L);

endmodule

// File: rtl/operand_sel_reg.sv
// ID/EX operand register: selects one of NSRC sources, with flush > stall > load
// priority, a sticky illegal-select flag and a saturating stall-hold counter.
module operand_sel_reg
    import operand_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH,
    parameter int NSRC  = OP_NSRC,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int CNTW  = OP_CNTW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [SELW-1:0]       out_sel,
    output logic                  sel_err,
    output logic [CNTW-1:0]       stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] mux_data;
    logic             mux_in_range;

    operand_mux_comb #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_mux (
        .src_data_i (src_data),
        .sel_i      (sel),
        .data_o     (mux_data),
        .in_range_o (mux_in_range)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (flush) begin
            data_d  = '0;
            valid_d = 1'b0;
            sel_d   = '0;
            cnt_d   = '0;
        end else if (stall) begin
            // Only a held real instruction counts as a stall cycle.
            if (!valid_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            data_d  = mux_in_range ? mux_data : '0;
            valid_d = in_valid;
            sel_d   = sel;
            cnt_d   = '0;
            err_d   = err_q | (in_valid & ~mux_in_range);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign sel_err   = err_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_sel_reg.sv
// Directed bench for operand_sel_reg: default build, a 3-source build and a
// 2-bit-counter build share one stimulus stream.
module tb_operand_sel_reg;

    logic         clk = 1'b0;
    logic         reset, stall, flush, in_valid;
    logic [127:0] src;
    logic [1:0]   sel;

    logic [31:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic [1:0]  a_sel, b_sel, c_sel;
    logic        a_err, b_err, c_err;
    logic [7:0]  a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_sel_reg dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .src_data(src), .sel(sel), .out_data(a_data), .out_valid(a_valid),
        .out_sel(a_sel), .sel_err(a_err), .stall_cnt(a_cnt)
    );

    operand_sel_reg #(.NSRC(3)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .src_data(src[95:0]), .sel(sel), .out_data(b_data), .out_valid(b_valid),
        .out_sel(b_sel), .sel_err(b_err), .stall_cnt(b_cnt)
    );

    operand_sel_reg #(.CNTW(2)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .src_data(src), .sel(sel), .out_data(c_data), .out_valid(c_valid),
        .out_sel(c_sel), .sel_err(c_err), .stall_cnt(c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 2'd0; src = '1;
        tick(); tick();
        n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", a_data); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", a_sel); end
        n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", b_err); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        src = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        sel = 2'd1; in_valid = 1'b1;
        tick();
        n_checks++; if (a_data !== 32'h2222_2222) begin n_fail++; $display("FAIL load_data got %h exp 22222222", a_data); end
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid got %b exp 1", a_valid); end
        n_checks++; if (a_sel !== 2'd1) begin n_fail++; $display("FAIL load_sel got %0d exp 1", a_sel); end
        n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL load_cnt got %0d exp 0", a_cnt); end
    endtask

    task automatic test_stall();
        stall = 1'b1; src = '1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (a_data !== 32'h2222_2222) begin n_fail++; $display("FAIL stall_hold[%0d] got %h exp 22222222", i, a_data); end
            n_checks++; if (a_cnt !== 8'(i)) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, a_cnt, i); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (a_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stall_release_data got %h exp ffffffff", a_data); end
        n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_release_cnt got %0d exp 0", a_cnt); end
    endtask

    task automatic test_sel_err();
        src = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        sel = 2'd3; in_valid = 1'b0;
        tick();
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL err_invalid got %b exp 0", b_err); end
        n_checks++; if (b_data !== 32'h0) begin n_fail++; $display("FAIL err_invalid_data got %h exp 0", b_data); end
        in_valid = 1'b1;
        tick();
        n_checks++; if (b_data !== 32'h0) begin n_fail++; $display("FAIL err_data got %h exp 0", b_data); end
        n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL err_valid got %b exp 1", b_valid); end
        n_checks++; if (b_sel !== 2'd3) begin n_fail++; $display("FAIL err_sel got %0d exp 3", b_sel); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", b_err); end
        n_checks++; if (a_data !== 32'h4444_4444) begin n_fail++; $display("FAIL pow2_src3 got %h exp 44444444", a_data); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL pow2_err got %b exp 0", a_err); end
        sel = 2'd0;
        tick();
        n_checks++; if (b_data !== 32'h1111_1111) begin n_fail++; $display("FAIL err_legal_data got %h exp 11111111", b_data); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", b_err); end
    endtask

    task automatic test_flush_stall();
        flush = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d] got %b exp 0", i, a_valid); end
            n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("FAIL flush_data[%0d] got %h exp 0", i, a_data); end
            n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt[%0d] got %0d exp 0", i, a_cnt); end
            n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL flush_err_kept[%0d] got %b exp 1", i, b_err); end
        end
        flush = 1'b0;
        tick();
        n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_bubble_cnt got %0d exp 0", a_cnt); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_valid got %b exp 0", a_valid); end
        stall = 1'b0;
    endtask

    task automatic test_saturate();
        sel = 2'd2; in_valid = 1'b1;
        tick();
        stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++; if (c_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, c_cnt, (i > 3) ? 3 : i); end
            n_checks++; if (a_cnt !== 8'(i)) begin n_fail++; $display("FAIL wide_cnt[%0d] got %0d exp %0d", i, a_cnt, i); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (c_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_release got %0d exp 0", c_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        sel = 2'd2; in_valid = 1'b1;
        tick();
        stall = 1'b1;
        repeat (5) tick();
        n_checks++; if (a_cnt !== 8'd5) begin n_fail++; $display("FAIL pre_reset_cnt got %0d exp 5", a_cnt); end
        reset = 1'b1;
        tick();
        n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("FAIL rst_stall_data got %h exp 0", a_data); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid got %b exp 0", a_valid); end
        n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL rst_stall_sel got %0d exp 0", a_sel); end
        n_checks++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_stall_cnt got %0d exp 0", a_cnt); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL rst_stall_err got %b exp 0", b_err); end
        reset = 1'b0; stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hDEAD_BEEF; exp_w[1] = 32'h0BAD_F00D;
        exp_w[2] = 32'h1234_5678; exp_w[3] = 32'hA5A5_5A5A;
        src = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        in_valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            sel = 2'(i);
            tick();
            n_checks++; if (a_data !== exp_w[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", i, a_data, exp_w[i]); end
            n_checks++; if (a_sel !== 2'(i)) begin n_fail++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", i, a_sel, i); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_invalid got %b exp 0", a_valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_sel_err();
        test_flush_stall();
        test_saturate();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_sel_reg.md
# operand_sel_reg

Parametrised N-source operand selector with an integrated pipeline register, replacing the fixed 2:1 register-file/immediate select at the ALU B input. Selects one of NSRC word-wide sources (register file, extended immediate, forwarded M/W-stage results), registers the result into the ID/EX boundary, and supports stall (hold) and flush (bubble). Also keeps a sticky illegal-select flag and a saturating stall-hold counter for debug and performance readout.

## Interface
- WIDTH, 32, data word width in bits
- NSRC, 4, number of selectable sources (≥2)
- SELW, $clog2(NSRC), select field width
- CNTW, 8, stall counter width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold the registered operand this cycle
- flush  in  1  replace the registered operand with a bubble
- in_valid  in  1  the current source set carries a real instruction
- src_data  in  NSRC*WIDTH  packed sources; source i is bits [i*WIDTH +: WIDTH]
- sel  in  SELW  source index
- out_data  out  WIDTH  registered selected operand
- out_valid  out  1  registered valid
- out_sel  out  SELW  registered select, for debug trace
- sel_err  out  1  sticky: an illegal select was loaded
- stall_cnt  out  CNTW  consecutive cycles a valid operand has been held

## Operation
- Per rising clk edge, in priority order: reset > flush > stall > load.
- reset: out_data=0, out_valid=0, out_sel=0, sel_err=0, stall_cnt=0.
- flush (stall ignored): out_data=0, out_valid=0, out_sel=0, stall_cnt=0; sel_err unchanged.
- stall, no flush: out_data, out_valid, out_sel held; stall_cnt increments if out_valid=1, saturating at 2^CNTW−1; stays 0 if out_valid=0.
- load (no reset/flush/stall): out_data<=src_data[sel] when sel<NSRC, else 0; out_valid<=in_valid; out_sel<=sel; stall_cnt<=0.
- sel_err set on a load with in_valid=1 and sel≥NSRC; cleared only by reset. An out-of-range sel with in_valid=0 does not set it.
- When NSRC is a power of two, no sel is out of range and sel_err never sets.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: the source selected in cycle n appears on out_data in cycle n+1.
- Stall is level-sensitive; hold lasts exactly as many cycles as stall is high.
- Reset asserted mid-stall or mid-flush wins in that same edge; first load possible on the cycle after reset deasserts.
- Flush and stall together for k cycles: out_valid=0 from the first edge; stall_cnt stays 0.
- stall_cnt at saturation stays at max until a load or flush.

## Structure
- Shared package operand_pkg: default WIDTH/NSRC/CNTW constants; source index constants SRC_GRF=0, SRC_EXT=1, SRC_FWD_M=2, SRC_FWD_W=3; used by the control decoder and the forwarding unit.
- One sub-module: operand_mux_comb — purely combinational NSRC:1 mux with range check (outputs selected word and an in_range bit); the top level holds the register, stall/flush priority, sticky flag and counter.

## Test plan
- Reset then load: src = {0x4444_4444, 0x3333_3333, 0x2222_2222, 0x1111_1111} (src3..src0), sel=1, in_valid=1 → next cycle out_data=0x2222_2222, out_valid=1, out_sel=1, stall_cnt=0.
- Stall 3 cycles after valid load, src changed to all 0xFFFF_FFFF → out_data held at 0x2222_2222, stall_cnt=1,2,3; first non-stall cycle loads the new value, stall_cnt=0.
- Flush and stall both high on one edge → out_valid=0, out_data=0, stall_cnt=0; sel_err unchanged.
- NSRC=3, sel=3, in_valid=1 → out_data=0, out_valid=1, sel_err=1 and stays 1 across later legal loads; same with in_valid=0 → sel_err stays 0.
- CNTW=2, stall held 6 cycles with out_valid=1 → stall_cnt 1,2,3,3,3,3.
- Reset asserted during a stall with stall_cnt=5 → all outputs 0 on that edge, including sel_err and stall_cnt.
